usb_tx_sequencer: RTL and testbench
===================================

// Module: usb_tx_sequencer
// PURPOSE
//  Packet-level control FSM for the USB transmit path. It drives the bit/byte
//  timer (Tim_rst, Tim_en, bit_sent) and consumes its new_bit, Load_Byte and
//  byte_out outputs. It selects the byte source for the shift register:
//  SYNC, PID, FIFO data, CRC16 lo/hi. It pops the TX FIFO, sequences EOP and
//  reports busy/done/error to the protocol layer.
// PARAMETERS
//  MAX_DATA   64   max data bytes per packet; larger tx_len is clamped
//  EOP_SE0    2    SE0 bit-times in EOP
// PORTS
//  clk          in   1  system clock
//  n_rst        in   1  asynchronous active-low reset
//  tx_start     in   1  one-cycle start request; honoured only in IDLE
//  tx_has_data  in   1  1 = DATA packet (data + CRC16); 0 = handshake (PID only)
//  tx_len       in   7  data byte count, latched at tx_start (0 allowed)
//  tx_abort     in   1  abandon packet; forces EOP
//  stuff_bit    in   1  bit stuffer inserting a stuffed bit this bit-time
//  new_bit      in   1  timer bit-period strobe
//  Load_Byte    in   1  timer byte-boundary strobe
//  byte_out     in   8  timer byte count
//  EOD          in   1  timer byte-count rollover
//  Tim_rst      out  1  timer synchronous clear
//  Tim_en       out  1  timer width-counter enable
//  bit_sent     out  1  = new_bit & ~stuff_bit & (state in SYNC..CRC_HI)
//  byte_sel     out  3  byte mux select (byte_sel_t)
//  fifo_pop     out  1  one-cycle TX FIFO read
//  crc_clr      out  1  clear CRC16 generator
//  drive_se0    out  1  line driver forces SE0
//  tx_busy      out  1  packet in progress
//  tx_done      out  1  one-cycle pulse at end of EOP
//  tx_err       out  1  sticky; set on EOD overflow or abort; cleared by tx_start
// BEHAVIOUR
//  Reset: state=IDLE. Outputs: Tim_rst=1, Tim_en=0, byte_sel=SEL_IDLE.
//   All other outputs 0. Latched len=0.
//  IDLE: Tim_rst=1. On tx_start: latch len=min(tx_len,MAX_DATA), pulse crc_clr,
//   clear tx_err, go to SYNC. From the next cycle: Tim_rst=0, Tim_en=1, tx_busy=1.
//  SYNC -> PID on Load_Byte.
//  PID on Load_Byte:
//   - !has_data -> EOP_SE0
//   - len==0 -> CRC_LO
//   - else -> DATA, with fifo_pop pulsed in the same cycle.
//  DATA: on each Load_Byte, compare remaining count (byte_out-1 vs len).
//   - More bytes remain: pop FIFO.
//   - Last byte done: go to CRC_LO with no pop.
//  CRC_LO -> CRC_HI -> EOP_SE0, each on Load_Byte.
//  EOP_SE0: drive_se0=1 for EOP_SE0 new_bit strobes, then EOP_J.
//   bit_sent=0 during EOP. Internal 2-bit counter.
//  EOP_J: one new_bit strobe. Then pulse tx_done, go to IDLE, assert Tim_rst.
//  byte_sel: IDLE=0, SYNC=1, PID=2, DATA=3, CRC_LO=4, CRC_HI=5.
//   Driven combinationally from the state.
//  stuff_bit during a new_bit: bit_sent is suppressed and the byte stretches
//   by one bit-time. The FSM must not advance, because no Load_Byte occurs.
//  EOD in SYNC..CRC_HI: set tx_err, go to EOP_SE0.
//  tx_abort in SYNC..CRC_HI: set tx_err, go to EOP_SE0 on the next cycle.
//   Ignored in IDLE and during EOP.
//  Simultaneous Load_Byte and tx_abort: abort wins, no fifo_pop.
//  tx_start while busy: ignored, no error.
//  n_rst low mid-packet: immediate IDLE. Line is not driven: no EOP, no tx_done.
// STRUCTURE
//  usb_tx_pkg holds:
//   - tx_state_t enum (IDLE,SYNC,PID,DATA,CRC_LO,CRC_HI,EOP_SE0,EOP_J)
//   - byte_sel_t enum
//   - SYNC_BYTE=8'h80
//  Single always_ff state/len/eop_cnt/tx_err register plus always_comb
//   next-state/output logic. No sub-module. The timer is a peer, wired at top level.
// TESTING
//  1. Handshake (has_data=0): tx_start -> 2 Load_Byte then 2 SE0 + 1 J bits;
//     tx_done once; fifo_pop count 0.
//  2. DATA, len=3 -> byte_sel 1,2,3,3,3,4,5. Exactly 3 fifo_pop. tx_done after
//     7 bytes + 3 EOP bits.
//  3. DATA, len=0 -> PID then CRC_LO directly; no fifo_pop; tx_err=0.
//  4. stuff_bit at bit 5 of PID -> PID lasts 9 bit-times; bit_sent count stays 8.
//  5. tx_abort mid-DATA on a Load_Byte cycle -> no pop; SE0 next cycle;
//     tx_err=1 until next tx_start.
//  6. n_rst low in CRC_HI -> all outputs at reset values in the same cycle;
//     tx_done never pulses.

Source files
------------

// File: rtl/usb_tx_pkg.sv
// usb_tx_pkg: state/byte-select types and constants shared by the USB transmit sequencer
package usb_tx_pkg;
  typedef enum logic [2:0] {
    ST_IDLE, ST_SYNC, ST_PID, ST_DATA, ST_CRC_LO, ST_CRC_HI, ST_EOP_SE0, ST_EOP_J
  } tx_state_t;
  typedef enum logic [2:0] {
    SEL_IDLE, SEL_SYNC, SEL_PID, SEL_DATA, SEL_CRC_LO, SEL_CRC_HI
  } byte_sel_t;
  localparam logic [7:0] SYNC_BYTE = 8'h80;
  // Byte-carrying states share their encoding with the matching mux select.
  function automatic byte_sel_t sel_of(input tx_state_t s);
    return (s >= ST_SYNC && s <= ST_CRC_HI) ? byte_sel_t'(s) : SEL_IDLE;
  endfunction
  function automatic logic [6:0] clamp_len(input logic [6:0] len, input int max_len);
    return (int'(len) > max_len) ? 7'(max_len) : len;
  endfunction
endpackage

// File: rtl/usb_tx_sequencer.sv
// usb_tx_sequencer: packet-level FSM for the USB transmit path; drives the bit/byte
// timer, selects the shift-register byte source, pops the TX FIFO and sequences EOP.
module usb_tx_sequencer
  import usb_tx_pkg::*;
#(
  parameter int MAX_DATA = 64,
  parameter int EOP_SE0  = 2
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       tx_start,
  input  logic       tx_has_data,
  input  logic [6:0] tx_len,
  input  logic       tx_abort,
  input  logic       stuff_bit,
  input  logic       new_bit,
  input  logic       Load_Byte,
  input  logic [7:0] byte_out,
  input  logic       EOD,
  output logic       Tim_rst,
  output logic       Tim_en,
  output logic       bit_sent,
  output logic [2:0] byte_sel,
  output logic       fifo_pop,
  output logic       crc_clr,
  output logic       drive_se0,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err
);
  localparam logic [1:0] EOP_LAST = 2'(EOP_SE0 - 1);
  tx_state_t  r_state, w_next;
  logic [6:0] r_len;
  logic       r_has_data, r_err, w_err;
  logic [1:0] r_eop_cnt, w_eop_cnt;
  logic       w_in_pkt, w_kill, w_more, w_go;
  assign w_in_pkt  = r_state >= ST_SYNC && r_state <= ST_CRC_HI;
  assign w_kill    = w_in_pkt & (tx_abort | EOD);
  assign w_go      = r_state == ST_IDLE && tx_start;
  // byte_out indexes the byte just finished (SYNC=0, PID=1, first data=2).
  assign w_more    = (byte_out - 8'd1) < {1'b0, r_len};
  assign w_err     = w_go ? 1'b0 : (w_kill | r_err);
  assign Tim_rst   = r_state == ST_IDLE;
  assign Tim_en    = ~Tim_rst;
  assign tx_busy   = ~Tim_rst;
  assign drive_se0 = r_state == ST_EOP_SE0;
  assign bit_sent  = new_bit & ~stuff_bit & w_in_pkt;
  assign byte_sel  = sel_of(r_state);
  assign crc_clr   = w_go;
  assign tx_err    = r_err;
  always_comb begin
    w_next    = r_state;
    w_eop_cnt = r_eop_cnt;
    fifo_pop  = 1'b0;
    tx_done   = 1'b0;
    if (w_kill) w_next = ST_EOP_SE0;
    else
      case (r_state)
        ST_IDLE:   w_next = tx_start ? ST_SYNC : ST_IDLE;
        ST_SYNC:   w_next = Load_Byte ? ST_PID : ST_SYNC;
        ST_PID: if (Load_Byte) begin
          w_next   = !r_has_data ? ST_EOP_SE0 : (r_len == 7'd0 ? ST_CRC_LO : ST_DATA);
          fifo_pop = r_has_data && r_len != 7'd0;
        end
        ST_DATA: if (Load_Byte) begin
          w_next   = w_more ? ST_DATA : ST_CRC_LO;
          fifo_pop = w_more;
        end
        ST_CRC_LO: w_next = Load_Byte ? ST_CRC_HI : ST_CRC_LO;
        ST_CRC_HI: w_next = Load_Byte ? ST_EOP_SE0 : ST_CRC_HI;
        ST_EOP_SE0: if (new_bit) begin
          w_next    = r_eop_cnt == EOP_LAST ? ST_EOP_J : ST_EOP_SE0;
          w_eop_cnt = r_eop_cnt == EOP_LAST ? 2'd0 : r_eop_cnt + 2'd1;
        end
        ST_EOP_J: if (new_bit) begin
          w_next  = ST_IDLE;
          tx_done = 1'b1;
        end
        default:   w_next = ST_IDLE;
      endcase
  end
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      r_state    <= ST_IDLE;
      r_len      <= 7'd0;
      r_has_data <= 1'b0;
      r_eop_cnt  <= 2'd0;
      r_err      <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_eop_cnt <= w_eop_cnt;
      r_err     <= w_err;
      if (w_go) begin
        r_len      <= clamp_len(tx_len, MAX_DATA);
        r_has_data <= tx_has_data;
      end
    end
endmodule

// File: tb/tb_usb_tx_sequencer.sv
// tb_usb_tx_sequencer: directed packets against a bit/byte timer model, with an
// expected byte_sel scoreboard popped on every Load_Byte.
module tb_usb_tx_sequencer;
  logic clk = 1'b0, n_rst = 1'b0;
  logic tx_start = 1'b0, tx_has_data = 1'b0, tx_abort = 1'b0, EOD = 1'b0, stuff_arm = 1'b0;
  logic [6:0] tx_len = 7'd0;
  logic stuff_bit, new_bit, Load_Byte;
  logic [7:0] byte_out;
  logic Tim_rst, Tim_en, bit_sent, fifo_pop, crc_clr, drive_se0, tx_busy, tx_done, tx_err;
  logic [2:0] byte_sel;
  logic t_div = 1'b0, stuff_used = 1'b0, sb_on = 1'b0;
  logic [2:0] t_bits = 3'd0;
  logic [7:0] byte_cnt = 8'd0;
  logic [2:0] exp_q[$];
  int total = 0, bad = 0;
  int cyc, pops, dones, se0_bits, sent, pid_bits, pid_sent, done_cyc;

  usb_tx_sequencer dut (
    .clk(clk), .n_rst(n_rst), .tx_start(tx_start), .tx_has_data(tx_has_data),
    .tx_len(tx_len), .tx_abort(tx_abort), .stuff_bit(stuff_bit), .new_bit(new_bit),
    .Load_Byte(Load_Byte), .byte_out(byte_out), .EOD(EOD), .Tim_rst(Tim_rst),
    .Tim_en(Tim_en), .bit_sent(bit_sent), .byte_sel(byte_sel), .fifo_pop(fifo_pop),
    .crc_clr(crc_clr), .drive_se0(drive_se0), .tx_busy(tx_busy), .tx_done(tx_done),
    .tx_err(tx_err)
  );

  always #5 clk = ~clk;

  // Timer model: one bit-time every two clocks, 8 unstuffed bits per byte.
  assign new_bit   = Tim_en && t_div;
  assign stuff_bit = stuff_arm && !stuff_used && new_bit && byte_cnt == 8'd1 && t_bits == 3'd5;
  assign Load_Byte = new_bit && !stuff_bit && t_bits == 3'd7;
  assign byte_out  = byte_cnt;
  always @(posedge clk)
    if (Tim_rst) begin
      t_div <= 1'b0; t_bits <= 3'd0; byte_cnt <= 8'd0; stuff_used <= 1'b0;
    end else if (Tim_en) begin
      t_div <= ~t_div;
      if (new_bit && !stuff_bit) t_bits <= t_bits + 3'd1;
      if (Load_Byte) byte_cnt <= byte_cnt + 8'd1;
      if (stuff_bit) stuff_used <= 1'b1;
    end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic sample();
    cyc++;
    pops += int'(fifo_pop);
    dones += int'(tx_done);
    sent += int'(bit_sent);
    se0_bits += int'(new_bit && drive_se0);
    if (byte_cnt == 8'd1 && new_bit) pid_bits++;
    if (byte_cnt == 8'd1 && bit_sent) pid_sent++;
    if (tx_done) done_cyc = cyc;
    if (sb_on && Load_Byte && !drive_se0) begin
      chk("sb_pending", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) chk("byte_sel", 32'(byte_sel), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
  endtask

  task automatic start(input logic has, input logic [6:0] len);
    tx_has_data = has; tx_len = len; tx_start = 1'b1;
    #1 chk("crc_clr_pulse", 32'(crc_clr), 1);
    cyc = 0; pops = 0; dones = 0; se0_bits = 0; sent = 0; pid_bits = 0; pid_sent = 0; done_cyc = 0;
    sb_on = 1'b1;
    tick();
    tx_start = 1'b0;
    chk("busy_after_start", 32'(tx_busy), 1);
    chk("tim_en_after_start", 32'(Tim_en), 1);
  endtask

  task automatic run_done(input int budget);
    int n = 0;
    while (!tx_done && n < budget) begin tick(); n++; end
    chk("done_seen", 32'(tx_done), 1);
    repeat (4) tick();
    chk("done_once", 32'(dones), 1);
    chk("idle_tim_rst", 32'(Tim_rst), 1);
    chk("idle_busy", 32'(tx_busy), 0);
    chk("sb_empty", 32'(exp_q.size()), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    repeat (2) tick();
    chk("rst_tim_rst", 32'(Tim_rst), 1);
    chk("rst_tim_en", 32'(Tim_en), 0);
    chk("rst_byte_sel", 32'(byte_sel), 0);
    chk("rst_busy", 32'(tx_busy), 0);
    chk("rst_err", 32'(tx_err), 0);
    chk("rst_se0", 32'(drive_se0), 0);
    n_rst = 1'b1;
    repeat (2) tick();
    // handshake
    exp_q = '{3'd1, 3'd2};
    start(1'b0, 7'd9);
    run_done(200);
    chk("hs_cycles", 32'(done_cyc), 38);
    chk("hs_pops", 32'(pops), 0);
    chk("hs_se0_bits", 32'(se0_bits), 2);
    chk("hs_bits_sent", 32'(sent), 16);
    // DATA len=3, with an ignored tx_start mid-packet
    exp_q = '{3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd4, 3'd5};
    start(1'b1, 7'd3);
    repeat (20) tick();
    tx_start = 1'b1;
    #1 chk("busy_start_no_clr", 32'(crc_clr), 0);
    tick();
    tx_start = 1'b0;
    run_done(400);
    chk("d3_cycles", 32'(done_cyc), 118);
    chk("d3_pops", 32'(pops), 3);
    chk("d3_bits_sent", 32'(sent), 56);
    chk("d3_err", 32'(tx_err), 0);
    // DATA len=0
    exp_q = '{3'd1, 3'd2, 3'd4, 3'd5};
    start(1'b1, 7'd0);
    run_done(300);
    chk("d0_cycles", 32'(done_cyc), 70);
    chk("d0_pops", 32'(pops), 0);
    chk("d0_err", 32'(tx_err), 0);
    // stuffed bit inside PID
    stuff_arm = 1'b1;
    exp_q = '{3'd1, 3'd2};
    start(1'b0, 7'd0);
    run_done(200);
    stuff_arm = 1'b0;
    chk("stuff_pid_bits", 32'(pid_bits), 9);
    chk("stuff_pid_sent", 32'(pid_sent), 8);
    chk("stuff_cycles", 32'(done_cyc), 40);
    // abort on the Load_Byte ending the first data byte
    exp_q = '{3'd1, 3'd2, 3'd3};
    start(1'b1, 7'd3);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (Load_Byte && byte_cnt == 8'd2) break;
      sample();
    end
    chk("abort_point_reached", 32'(Load_Byte && byte_cnt == 8'd2), 1);
    tx_abort = 1'b1;
    #1 chk("abort_no_pop", 32'(fifo_pop), 0);
    sample();
    tick();
    tx_abort = 1'b0;
    chk("abort_se0_next", 32'(drive_se0), 1);
    chk("abort_err_set", 32'(tx_err), 1);
    run_done(50);
    chk("abort_pops", 32'(pops), 1);
    chk("abort_se0_bits", 32'(se0_bits), 2);
    chk("abort_err_sticky", 32'(tx_err), 1);
    exp_q = '{3'd1, 3'd2};
    start(1'b0, 7'd0);
    chk("err_cleared_by_start", 32'(tx_err), 0);
    run_done(200);
    // EOD during SYNC
    start(1'b1, 7'd5);
    repeat (3) tick();
    EOD = 1'b1;
    tick();
    EOD = 1'b0;
    chk("eod_se0", 32'(drive_se0), 1);
    chk("eod_err", 32'(tx_err), 1);
    run_done(50);
    chk("eod_pops", 32'(pops), 0);
    // tx_len above MAX_DATA is clamped
    exp_q = '{3'd1, 3'd2};
    for (int i = 0; i < 64; i++) exp_q.push_back(3'd3);
    exp_q.push_back(3'd4);
    exp_q.push_back(3'd5);
    start(1'b1, 7'd100);
    run_done(2000);
    chk("clamp_pops", 32'(pops), 64);
    chk("clamp_cycles", 32'(done_cyc), 1094);
    // reset in CRC_HI
    exp_q = '{3'd1, 3'd2, 3'd4};
    start(1'b1, 7'd0);
    for (int i = 0; i < 400; i++) begin
      tick();
      if (byte_cnt == 8'd3 && t_bits == 3'd3) break;
    end
    chk("crc_hi_sel", 32'(byte_sel), 5);
    n_rst = 1'b0;
    #1;
    chk("mid_rst_tim_rst", 32'(Tim_rst), 1);
    chk("mid_rst_tim_en", 32'(Tim_en), 0);
    chk("mid_rst_byte_sel", 32'(byte_sel), 0);
    chk("mid_rst_busy", 32'(tx_busy), 0);
    chk("mid_rst_se0", 32'(drive_se0), 0);
    chk("mid_rst_bit_sent", 32'(bit_sent), 0);
    chk("mid_rst_done", 32'(tx_done), 0);
    chk("sb_empty_at_rst", 32'(exp_q.size()), 0);
    repeat (3) tick();
    n_rst = 1'b1;
    repeat (60) tick();
    chk("no_done_after_rst", 32'(dones), 0);
    chk("idle_after_rst", 32'(Tim_rst), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
